// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM encoding,
// default timeout and the strobe-width helper.
package dmem_bus_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int DEFAULT_TIMEOUT = 255;

   // One strobe bit per byte lane.
   function automatic int strb_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter bounding how long a bus transaction may stay outstanding.
// tc is high while the count sits at TIMEOUT_CYCLES-1; the count holds
// there so it never wraps back into a non-terminal value.
module bus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Clear at transaction start, count while outstanding, saturate at terminal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != TERM))
         count <= count + CNT_W'(1);
   end

   assign tc = (count == TERM);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's single-cycle load/store port onto a valid/ready
// request + response bus. The core is stalled while a transaction is
// outstanding; completion is a one-cycle DONE state that releases the stall,
// presents load data and flags slave errors or timeouts.
module dmem_bus_bridge
   import dmem_bus_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                core_rd_req_in,
   input  logic                core_wr_req_in,
   input  logic [ADDR_W-1:0]   core_addr_in,
   input  logic [DATA_W-1:0]   core_wdata_in,
   input  logic [DATA_W/8-1:0] core_wr_mask_in,
   output logic                core_stall_out,
   output logic [DATA_W-1:0]   core_rdata_out,
   output logic                core_bus_err_out,
   output logic                bus_valid_out,
   input  logic                bus_ready_in,
   output logic                bus_we_out,
   output logic [ADDR_W-1:0]   bus_addr_out,
   output logic [DATA_W-1:0]   bus_wdata_out,
   output logic [DATA_W/8-1:0] bus_strb_out,
   input  logic                bus_resp_valid_in,
   input  logic                bus_resp_err_in,
   input  logic [DATA_W-1:0]   bus_rdata_in
);

   localparam int STRB_W = strb_width(DATA_W);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              req_any;
   logic              start;
   logic              in_req;
   logic              in_resp;
   logic              in_done;
   logic              complete;
   logic              tmo_tc;
   logic              timeout;

   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;

   assign req_any = core_rd_req_in | core_wr_req_in;
   assign in_req  = (state == ST_REQ);
   assign in_resp = (state == ST_RESP);
   assign in_done = (state == ST_DONE);
   assign start   = (state == ST_IDLE) & req_any;

   // A response only counts once the request has been accepted, either in
   // the accepting REQ cycle itself or later in RESP.
   assign complete = bus_resp_valid_in & ((in_req & bus_ready_in) | in_resp);
   // A genuine response in the terminal cycle wins over the timeout.
   assign timeout  = (in_req | in_resp) & tmo_tc & ~complete;

   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk (clk_in),
      .rst (rst_in),
      .clr (start),
      .en  (in_req | in_resp),
      .tc  (tmo_tc)
   );

   // Next-state selection for the IDLE -> REQ -> RESP -> DONE sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_any) state_nxt = ST_REQ;
         ST_REQ: begin
            if (complete || timeout) state_nxt = ST_DONE;
            else if (bus_ready_in)   state_nxt = ST_RESP;
         end
         ST_RESP: if (complete || timeout) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset aborts any outstanding transaction immediately.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Capture the request at start (write wins over read) and record the outcome.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (start) begin
            we_q    <= core_wr_req_in;
            addr_q  <= core_addr_in;
            wdata_q <= core_wdata_in;
            strb_q  <= core_wr_req_in ? core_wr_mask_in : {STRB_W{1'b1}};
         end
         if (complete) begin
            err_q <= bus_resp_err_in;
            if (!we_q) rdata_q <= bus_resp_err_in ? '0 : bus_rdata_in;
         end else if (timeout) begin
            err_q <= 1'b1;
            if (!we_q) rdata_q <= '0;
         end
      end
   end

   assign core_stall_out   = ~rst_in & (start | in_req | in_resp);
   assign core_rdata_out   = rdata_q;
   assign core_bus_err_out = in_done & err_q;
   assign bus_valid_out    = in_req;
   assign bus_we_out       = we_q;
   assign bus_addr_out     = addr_q;
   assign bus_wdata_out    = wdata_q;
   assign bus_strb_out     = strb_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: a table of load/store transactions with
// hand-computed results, followed by timeout, late-response and reset sequences.
module tb_dmem_bus_bridge;

   localparam int NEVER = 1000;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          ready_d;   // valid cycles before ready is given
      int          resp_d;    // cycles after accept before response (0 = with ready)
      logic        resp_err;
      logic [31:0] rdata;
      logic        exp_we;
      logic [3:0]  exp_strb;
      int          exp_stall;
      int          exp_valid;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        core_rd_req_in, core_wr_req_in;
   logic [31:0] core_addr_in, core_wdata_in;
   logic [3:0]  core_wr_mask_in;
   logic        core_stall_out;
   logic [31:0] core_rdata_out;
   logic        core_bus_err_out;
   logic        bus_valid_out, bus_ready_in, bus_we_out;
   logic [31:0] bus_addr_out, bus_wdata_out;
   logic [3:0]  bus_strb_out;
   logic        bus_resp_valid_in, bus_resp_err_in;
   logic [31:0] bus_rdata_in;

   int n_chk  = 0;
   int n_fail = 0;
   vec_t vecs[10];

   dmem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .core_rd_req_in(core_rd_req_in), .core_wr_req_in(core_wr_req_in),
      .core_addr_in(core_addr_in), .core_wdata_in(core_wdata_in),
      .core_wr_mask_in(core_wr_mask_in), .core_stall_out(core_stall_out),
      .core_rdata_out(core_rdata_out), .core_bus_err_out(core_bus_err_out),
      .bus_valid_out(bus_valid_out), .bus_ready_in(bus_ready_in),
      .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
      .bus_wdata_out(bus_wdata_out), .bus_strb_out(bus_strb_out),
      .bus_resp_valid_in(bus_resp_valid_in), .bus_resp_err_in(bus_resp_err_in),
      .bus_rdata_in(bus_rdata_in)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask,
                               input int rdy, input int rsp, input logic rerr,
                               input logic [31:0] rdat, input logic ewe,
                               input logic [3:0] estrb, input int estall, input int evalid,
                               input logic eerr, input logic [31:0] erdata);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mask = mask;
      v.ready_d = rdy; v.resp_d = rsp; v.resp_err = rerr; v.rdata = rdat;
      v.exp_we = ewe; v.exp_strb = estrb; v.exp_stall = estall; v.exp_valid = evalid;
      v.exp_err = eerr; v.exp_rdata = erdata;
      return v;
   endfunction

   task automatic clear_slave();
      bus_ready_in = 1'b0; bus_resp_valid_in = 1'b0;
      bus_resp_err_in = 1'b0; bus_rdata_in = 32'h0;
   endtask

   // Drive one core request, play the slave, then check completion and the
   // idle cycle that follows it.
   task automatic run_txn(input string name, input vec_t v);
      int  cyc, stall_n, valid_n, wait_n;
      bit  acc, done;
      cyc = 0; stall_n = 0; valid_n = 0; wait_n = 0; acc = 0; done = 0;
      @(negedge clk_in);
      core_rd_req_in = v.rd; core_wr_req_in = v.wr;
      core_addr_in = v.addr; core_wdata_in = v.wdata; core_wr_mask_in = v.mask;
      while (!done) begin
         clear_slave();
         if (bus_valid_out) begin
            valid_n++;
            check({name, " bus_addr"},  bus_addr_out,  v.addr);
            check({name, " bus_wdata"}, bus_wdata_out, v.wdata);
            check({name, " bus_we"},    bus_we_out,    v.exp_we);
            check({name, " bus_strb"},  bus_strb_out,  v.exp_strb);
            if (v.ready_d != NEVER && valid_n > v.ready_d) begin
               bus_ready_in = 1'b1;
               acc = 1;
               if (v.resp_d == 0) begin
                  bus_resp_valid_in = 1'b1; bus_resp_err_in = v.resp_err; bus_rdata_in = v.rdata;
               end
            end
         end else if (acc) begin
            wait_n++;
            if (v.resp_d != NEVER && wait_n >= v.resp_d) begin
               bus_resp_valid_in = 1'b1; bus_resp_err_in = v.resp_err; bus_rdata_in = v.rdata;
            end
         end
         #1;
         if (core_stall_out) stall_n++;
         else begin
            done = 1;
            check({name, " stall_cycles"}, stall_n, v.exp_stall);
            check({name, " valid_cycles"}, valid_n, v.exp_valid);
            check({name, " err_done"},     core_bus_err_out, v.exp_err);
            check({name, " rdata_done"},   core_rdata_out, v.exp_rdata);
         end
         cyc++;
         if (!done) begin
            if (cyc > 60) begin
               n_chk++; n_fail++;
               $display("FAIL %s completion: got no completion in %0d cycles, required completion", name, cyc);
               done = 1;
            end else begin
               @(negedge clk_in);
            end
         end
      end
      @(negedge clk_in);
      core_rd_req_in = 1'b0; core_wr_req_in = 1'b0;
      clear_slave();
      #1;
      check({name, " idle_stall"}, core_stall_out, 1'b0);
      check({name, " idle_err"},   core_bus_err_out, 1'b0);
      check({name, " idle_rdata"}, core_rdata_out, v.exp_rdata);
   endtask

   initial begin
      rst_in = 1'b1;
      core_rd_req_in = 1'b0; core_wr_req_in = 1'b0;
      core_addr_in = 32'h0; core_wdata_in = 32'h0; core_wr_mask_in = 4'h0;
      clear_slave();

      //           rd wr addr          wdata         mask rdy   rsp   err rdata         we strb stall val err exp_rdata
      vecs[0] = mk(1, 0, 32'h100, 32'h0,         4'h0, 0,     1,    0, 32'hDEADBEEF, 0, 4'hF, 3, 1, 0, 32'hDEADBEEF);
      vecs[1] = mk(0, 1, 32'h204, 32'h11223344,  4'h3, 4,     1,    0, 32'h55555555, 1, 4'h3, 7, 5, 0, 32'hDEADBEEF);
      vecs[2] = mk(1, 1, 32'h300, 32'hA5A5A5A5,  4'h9, 0,     0,    0, 32'h66666666, 1, 4'h9, 2, 1, 0, 32'hDEADBEEF);
      vecs[3] = mk(1, 0, 32'h104, 32'h0,         4'h0, 0,     2,    1, 32'hFFFFFFFF, 0, 4'hF, 4, 1, 1, 32'h0);
      vecs[4] = mk(1, 0, 32'h108, 32'h0,         4'h0, 1,     0,    0, 32'h12345678, 0, 4'hF, 3, 2, 0, 32'h12345678);
      vecs[5] = mk(1, 0, 32'h10C, 32'h0,         4'h0, NEVER, NEVER,0, 32'h0,        0, 4'hF, 9, 8, 1, 32'h0);
      vecs[6] = mk(1, 0, 32'h110, 32'h0,         4'h0, 0,     1,    0, 32'hCAFEF00D, 0, 4'hF, 3, 1, 0, 32'hCAFEF00D);
      vecs[7] = mk(0, 1, 32'h114, 32'hFEEDFACE,  4'hC, 2,     NEVER,0, 32'h0,        1, 4'hC, 9, 3, 1, 32'hCAFEF00D);
      vecs[8] = mk(1, 0, 32'h118, 32'h0,         4'h0, 0,     7,    0, 32'h0BADC0DE, 0, 4'hF, 9, 1, 0, 32'h0BADC0DE);
      vecs[9] = mk(0, 1, 32'h11C, 32'h01020304,  4'h1, 0,     0,    1, 32'h0,        1, 4'h1, 2, 1, 1, 32'h0BADC0DE);

      // Reset state
      repeat (3) @(negedge clk_in);
      #1;
      check("reset stall", core_stall_out, 1'b0);
      check("reset valid", bus_valid_out, 1'b0);
      check("reset we",    bus_we_out, 1'b0);
      check("reset addr",  bus_addr_out, 32'h0);
      check("reset wdata", bus_wdata_out, 32'h0);
      check("reset strb",  bus_strb_out, 4'h0);
      check("reset rdata", core_rdata_out, 32'h0);
      check("reset err",   core_bus_err_out, 1'b0);
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 10; i++)
         run_txn($sformatf("vec%0d", i), vecs[i]);

      // Timeout after accept, then a late response arriving in IDLE
      run_txn("timeout", mk(1, 0, 32'h120, 32'h0, 4'h0, 0, NEVER, 0, 32'h0,
                            0, 4'hF, 9, 1, 1, 32'h0));
      bus_resp_valid_in = 1'b1; bus_resp_err_in = 1'b1; bus_rdata_in = 32'h77777777;
      @(negedge clk_in);
      clear_slave();
      #1;
      check("late_resp stall", core_stall_out, 1'b0);
      check("late_resp err",   core_bus_err_out, 1'b0);
      check("late_resp rdata", core_rdata_out, 32'h0);
      check("late_resp valid", bus_valid_out, 1'b0);

      // Reset during RESP with the request still held
      run_txn("pre_rst", mk(1, 0, 32'h130, 32'h0, 4'h0, 0, 1, 0, 32'h13579BDF,
                            0, 4'hF, 3, 1, 0, 32'h13579BDF));
      @(negedge clk_in);
      core_rd_req_in = 1'b1; core_addr_in = 32'h400;
      @(negedge clk_in);
      bus_ready_in = 1'b1;
      #1;
      check("rst_resp req_valid", bus_valid_out, 1'b1);
      @(negedge clk_in);
      clear_slave();
      #1;
      check("rst_resp in_resp_stall", core_stall_out, 1'b1);
      rst_in = 1'b1;
      #1;
      check("rst_resp stall", core_stall_out, 1'b0);
      check("rst_resp valid", bus_valid_out, 1'b0);
      check("rst_resp rdata", core_rdata_out, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b0; core_rd_req_in = 1'b0;
      bus_resp_valid_in = 1'b1; bus_rdata_in = 32'h99999999;
      @(negedge clk_in);
      clear_slave();
      #1;
      check("dropped_resp rdata", core_rdata_out, 32'h0);
      check("dropped_resp stall", core_stall_out, 1'b0);

      // Reset during REQ: valid must drop without waiting for a clock
      core_rd_req_in = 1'b1; core_addr_in = 32'h500;
      @(negedge clk_in);
      #1;
      check("rst_req valid_before", bus_valid_out, 1'b1);
      rst_in = 1'b1;
      #1;
      check("rst_req valid", bus_valid_out, 1'b0);
      @(negedge clk_in);
      rst_in = 1'b0; core_rd_req_in = 1'b0;

      // Fresh load after reset
      run_txn("post_rst", mk(1, 0, 32'h600, 32'h0, 4'h0, 0, 1, 0, 32'h600DF00D,
                             0, 4'hF, 3, 1, 0, 32'h600DF00D));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
